// File: rtl/replay_controller_if.sv
// rtl/replay_controller_if.sv - TLP transmit, DLLP receive and replay buffer signals of the replay controller
interface replay_controller_if;
  logic        tlp_sent;
  logic        dllp_valid;
  logic        dllp_nak;
  logic [11:0] dllp_seq;
  logic        replay_done;
  logic        retrain_done;
  logic [11:0] next_seq;
  logic [11:0] ackd_seq;
  logic [11:0] outstanding;
  logic        purge_valid;
  logic [11:0] purge_seq;
  logic        replay_req;
  logic        tx_block;
  logic        link_retrain;
  logic        dllp_err;

  modport slave (
    input  tlp_sent, dllp_valid, dllp_nak, dllp_seq, replay_done, retrain_done,
    output next_seq, ackd_seq, outstanding, purge_valid, purge_seq,
           replay_req, tx_block, link_retrain, dllp_err
  );

  modport master (
    output tlp_sent, dllp_valid, dllp_nak, dllp_seq, replay_done, retrain_done,
    input  next_seq, ackd_seq, outstanding, purge_valid, purge_seq,
           replay_req, tx_block, link_retrain, dllp_err
  );
endinterface

// File: rtl/replay_controller.sv
// rtl/replay_controller.sv - data link layer replay sequencing: sequence numbers, ACK/NAK purge, replay timer, retrain escalation
module replay_controller #(
  parameter int TIMEOUT         = 1024,
  parameter int MAX_OUTSTANDING = 1024
) (
  input  logic clk,
  input  logic reset,
  replay_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPLAY, S_RETRAIN} state_t;

  state_t      r_state, w_state_n;
  logic [11:0] r_next_seq, r_ackd_seq, r_outstanding, r_purge_seq;
  logic [15:0] r_timer, w_timer_n;
  logic        r_timer_run, w_timer_run_n;
  logic [1:0]  r_replay_num, w_rnum_n, w_rnum_base;
  logic        r_purge_valid, r_replay_req, r_tx_block, r_link_retrain, r_dllp_err;

  logic        w_tlp_acc, w_fwd, w_dup, w_err, w_nak_hit, w_expire, w_trig;
  logic [11:0] w_d, w_next_seq_n, w_ackd_n, w_out_n;

  // DLLP offset is judged against the pre-update pointers, even when a TLP is sent the same cycle
  assign w_tlp_acc    = bus.tlp_sent && !r_tx_block;
  assign w_d          = bus.dllp_seq - r_ackd_seq;
  assign w_dup        = bus.dllp_valid && (w_d == 12'd0);
  assign w_fwd        = bus.dllp_valid && (w_d != 12'd0) && (w_d <= r_outstanding);
  assign w_err        = bus.dllp_valid && (w_d > r_outstanding);
  assign w_nak_hit    = bus.dllp_nak && (w_dup || w_fwd);
  assign w_next_seq_n = r_next_seq + {11'd0, w_tlp_acc};
  assign w_ackd_n     = w_fwd ? bus.dllp_seq : r_ackd_seq;
  assign w_out_n      = w_next_seq_n - w_ackd_n - 12'd1;
  assign w_expire     = r_timer_run && (r_timer == 16'(TIMEOUT - 1));
  assign w_rnum_base  = w_fwd ? 2'd0 : r_replay_num;
  assign w_trig       = (w_expire || w_nak_hit) && (w_out_n != 12'd0);

  always_comb begin
    w_state_n = r_state;
    w_rnum_n  = w_rnum_base;
    case (r_state)
      S_IDLE: if (w_out_n != 12'd0) w_state_n = S_RUN;
      S_RUN: begin
        if (w_trig) begin
          if (w_rnum_base < 2'd3) begin
            w_rnum_n  = w_rnum_base + 2'd1;
            w_state_n = S_REPLAY;
          end else begin
            w_rnum_n  = 2'd0;
            w_state_n = S_RETRAIN;
          end
        end else if (w_out_n == 12'd0) begin
          w_state_n = S_IDLE;
        end
      end
      S_REPLAY:  if (bus.replay_done) w_state_n = (w_out_n == 12'd0) ? S_IDLE : S_RUN;
      S_RETRAIN: if (bus.retrain_done) w_state_n = S_REPLAY;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Timer runs only in RUN; any ACK progress or replay completion restarts it from zero
  always_comb begin
    w_timer_n     = r_timer;
    w_timer_run_n = r_timer_run;
    if (w_state_n == S_REPLAY || w_state_n == S_RETRAIN) begin
      w_timer_n     = 16'd0;
      w_timer_run_n = 1'b0;
    end else if (r_state == S_REPLAY) begin
      w_timer_n     = 16'd0;
      w_timer_run_n = (w_state_n == S_RUN);
    end else if (w_out_n == 12'd0) begin
      w_timer_n     = 16'd0;
      w_timer_run_n = 1'b0;
    end else if (w_fwd || (w_tlp_acc && !r_timer_run)) begin
      w_timer_n     = 16'd0;
      w_timer_run_n = 1'b1;
    end else if (r_timer_run) begin
      w_timer_n     = r_timer + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_next_seq     <= 12'd0;
      r_ackd_seq     <= 12'd4095;
      r_outstanding  <= 12'd0;
      r_timer        <= 16'd0;
      r_timer_run    <= 1'b0;
      r_replay_num   <= 2'd0;
      r_purge_valid  <= 1'b0;
      r_purge_seq    <= 12'd0;
      r_replay_req   <= 1'b0;
      r_tx_block     <= 1'b0;
      r_link_retrain <= 1'b0;
      r_dllp_err     <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_next_seq     <= w_next_seq_n;
      r_ackd_seq     <= w_ackd_n;
      r_outstanding  <= w_out_n;
      r_timer        <= w_timer_n;
      r_timer_run    <= w_timer_run_n;
      r_replay_num   <= w_rnum_n;
      r_purge_valid  <= w_fwd;
      if (w_fwd) r_purge_seq <= bus.dllp_seq;
      r_replay_req   <= (w_state_n == S_REPLAY);
      r_link_retrain <= (w_state_n == S_RETRAIN);
      r_tx_block     <= (w_state_n == S_REPLAY) || (w_state_n == S_RETRAIN) ||
                        (w_out_n == 12'(MAX_OUTSTANDING));
      r_dllp_err     <= w_err;
    end
  end

  assign bus.next_seq     = r_next_seq;
  assign bus.ackd_seq     = r_ackd_seq;
  assign bus.outstanding  = r_outstanding;
  assign bus.purge_valid  = r_purge_valid;
  assign bus.purge_seq    = r_purge_seq;
  assign bus.replay_req   = r_replay_req;
  assign bus.tx_block     = r_tx_block;
  assign bus.link_retrain = r_link_retrain;
  assign bus.dllp_err     = r_dllp_err;

endmodule

// File: tb/tb_replay_controller.sv
// tb/tb_replay_controller.sv - directed self-checking bench for replay_controller
module tb_replay_controller;
  localparam int TO   = 16;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  replay_controller_if bus();

  replay_controller #(.TIMEOUT(TO), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.tlp_sent = 0; bus.dllp_valid = 0; bus.dllp_nak = 0; bus.dllp_seq = 0;
    bus.replay_done = 0; bus.retrain_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic send_tlp();
    bus.tlp_sent = 1; step(); bus.tlp_sent = 0;
  endtask

  task automatic send_dllp(input logic nak, input logic [11:0] seq);
    bus.dllp_valid = 1; bus.dllp_nak = nak; bus.dllp_seq = seq;
    step();
    bus.dllp_valid = 0; bus.dllp_nak = 0;
  endtask

  task automatic test_reset();
    do_reset();
    send_tlp(); send_tlp();
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (bus.next_seq !== 12'd0) begin errors++; $display("FAIL rst_next_seq got %0d exp 0", bus.next_seq); end
    checks++; if (bus.ackd_seq !== 12'd4095) begin errors++; $display("FAIL rst_ackd_seq got %0d exp 4095", bus.ackd_seq); end
    checks++; if (bus.outstanding !== 12'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", bus.outstanding); end
    checks++; if ({bus.purge_valid, bus.replay_req, bus.tx_block, bus.link_retrain, bus.dllp_err} !== 5'b0)
      begin errors++; $display("FAIL rst_flags got %b exp 00000", {bus.purge_valid, bus.replay_req, bus.tx_block, bus.link_retrain, bus.dllp_err}); end
    checks++; if (bus.purge_seq !== 12'd0) begin errors++; $display("FAIL rst_purge_seq got %0d exp 0", bus.purge_seq); end
  endtask

  task automatic test_ack();
    do_reset();
    repeat (3) send_tlp();
    send_dllp(1'b0, 12'd1);
    checks++; if (bus.next_seq !== 12'd3) begin errors++; $display("FAIL ack_next_seq got %0d exp 3", bus.next_seq); end
    checks++; if (bus.purge_valid !== 1'b1 || bus.purge_seq !== 12'd1) begin errors++; $display("FAIL ack_purge got v=%b s=%0d exp v=1 s=1", bus.purge_valid, bus.purge_seq); end
    checks++; if (bus.outstanding !== 12'd1) begin errors++; $display("FAIL ack_outstanding got %0d exp 1", bus.outstanding); end
    checks++; if (bus.ackd_seq !== 12'd1) begin errors++; $display("FAIL ack_ackd_seq got %0d exp 1", bus.ackd_seq); end
    step();
    checks++; if (bus.purge_valid !== 1'b0) begin errors++; $display("FAIL ack_purge_pulse got %b exp 0", bus.purge_valid); end
    repeat (TO - 2) step();
    checks++; if (bus.replay_req !== 1'b0) begin errors++; $display("FAIL ack_timer_restart_early got %b exp 0", bus.replay_req); end
    step();
    checks++; if (bus.replay_req !== 1'b1) begin errors++; $display("FAIL ack_timer_restart_expiry got %b exp 1", bus.replay_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_tlp(); send_tlp();
    repeat (TO - 2) step();
    checks++; if (bus.replay_req !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", bus.replay_req); end
    step();
    checks++; if (bus.replay_req !== 1'b1 || bus.tx_block !== 1'b1) begin errors++; $display("FAIL to_replay got req=%b blk=%b exp 1 1", bus.replay_req, bus.tx_block); end
    send_tlp();
    checks++; if (bus.next_seq !== 12'd2 || bus.outstanding !== 12'd2) begin errors++; $display("FAIL to_tlp_ignored got ns=%0d out=%0d exp 2 2", bus.next_seq, bus.outstanding); end
    bus.replay_done = 1; step(); bus.replay_done = 0;
    checks++; if (bus.replay_req !== 1'b0 || bus.tx_block !== 1'b0) begin errors++; $display("FAIL to_done got req=%b blk=%b exp 0 0", bus.replay_req, bus.tx_block); end
  endtask

  task automatic test_nak();
    do_reset();
    repeat (4) send_tlp();
    send_dllp(1'b1, 12'd1);
    checks++; if (bus.purge_valid !== 1'b1 || bus.purge_seq !== 12'd1) begin errors++; $display("FAIL nak_purge got v=%b s=%0d exp 1 1", bus.purge_valid, bus.purge_seq); end
    checks++; if (bus.replay_req !== 1'b1 || bus.outstanding !== 12'd2) begin errors++; $display("FAIL nak_replay got req=%b out=%0d exp 1 2", bus.replay_req, bus.outstanding); end
    send_dllp(1'b0, 12'd3);
    checks++; if (bus.purge_valid !== 1'b1 || bus.purge_seq !== 12'd3 || bus.outstanding !== 12'd0) begin errors++; $display("FAIL nak_ack_in_replay got v=%b s=%0d out=%0d exp 1 3 0", bus.purge_valid, bus.purge_seq, bus.outstanding); end
    checks++; if (bus.replay_req !== 1'b1) begin errors++; $display("FAIL nak_hold_replay got %b exp 1", bus.replay_req); end
    bus.replay_done = 1; step(); bus.replay_done = 0;
    checks++; if (bus.replay_req !== 1'b0 || bus.tx_block !== 1'b0) begin errors++; $display("FAIL nak_done got req=%b blk=%b exp 0 0", bus.replay_req, bus.tx_block); end
  endtask

  task automatic test_retrain();
    int n;
    do_reset();
    send_tlp(); send_tlp();
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (bus.replay_req !== 1'b1 && n < 4 * TO) begin step(); n++; end
      checks++; if (bus.replay_req !== 1'b1 || bus.link_retrain !== 1'b0) begin errors++; $display("FAIL rt_replay%0d got req=%b rt=%b exp 1 0", r, bus.replay_req, bus.link_retrain); end
      bus.replay_done = 1; step(); bus.replay_done = 0;
    end
    n = 0;
    while (bus.link_retrain !== 1'b1 && n < 4 * TO) begin step(); n++; end
    checks++; if (bus.link_retrain !== 1'b1 || bus.replay_req !== 1'b0 || bus.tx_block !== 1'b1) begin errors++; $display("FAIL rt_retrain got rt=%b req=%b blk=%b exp 1 0 1", bus.link_retrain, bus.replay_req, bus.tx_block); end
    bus.retrain_done = 1; step(); bus.retrain_done = 0;
    checks++; if (bus.link_retrain !== 1'b0 || bus.replay_req !== 1'b1) begin errors++; $display("FAIL rt_done got rt=%b req=%b exp 0 1", bus.link_retrain, bus.replay_req); end
    checks++; if (dut.r_replay_num !== 2'd0) begin errors++; $display("FAIL rt_replay_num got %0d exp 0", dut.r_replay_num); end
  endtask

  task automatic test_wrap();
    logic [11:0] s;
    do_reset();
    for (int i = 0; i < 4094; i++) begin
      s = 12'(i);
      send_tlp();
      send_dllp(1'b0, s);
    end
    checks++; if (bus.next_seq !== 12'd4094 || bus.outstanding !== 12'd0) begin errors++; $display("FAIL wr_preload got ns=%0d out=%0d exp 4094 0", bus.next_seq, bus.outstanding); end
    repeat (3) send_tlp();
    checks++; if (bus.next_seq !== 12'd1 || bus.outstanding !== 12'd3) begin errors++; $display("FAIL wr_wrap got ns=%0d out=%0d exp 1 3", bus.next_seq, bus.outstanding); end
    send_dllp(1'b0, 12'd0);
    checks++; if (bus.purge_valid !== 1'b1 || bus.purge_seq !== 12'd0 || bus.outstanding !== 12'd0 || bus.ackd_seq !== 12'd0) begin errors++; $display("FAIL wr_ack0 got v=%b s=%0d out=%0d ack=%0d exp 1 0 0 0", bus.purge_valid, bus.purge_seq, bus.outstanding, bus.ackd_seq); end
    send_dllp(1'b0, 12'd5);
    checks++; if (bus.dllp_err !== 1'b1 || bus.purge_valid !== 1'b0 || bus.ackd_seq !== 12'd0) begin errors++; $display("FAIL wr_err got err=%b v=%b ack=%0d exp 1 0 0", bus.dllp_err, bus.purge_valid, bus.ackd_seq); end
    step();
    checks++; if (bus.dllp_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse got %b exp 0", bus.dllp_err); end
    repeat (TO + 2) step();
    checks++; if (bus.replay_req !== 1'b0 || bus.tx_block !== 1'b0) begin errors++; $display("FAIL wr_idle got req=%b blk=%b exp 0 0", bus.replay_req, bus.tx_block); end
  endtask

  task automatic test_full();
    do_reset();
    repeat (MAXO) send_tlp();
    checks++; if (bus.tx_block !== 1'b1 || bus.outstanding !== 12'(MAXO)) begin errors++; $display("FAIL full_block got blk=%b out=%0d exp 1 %0d", bus.tx_block, bus.outstanding, MAXO); end
    send_tlp();
    checks++; if (bus.next_seq !== 12'(MAXO)) begin errors++; $display("FAIL full_ignored got %0d exp %0d", bus.next_seq, MAXO); end
    send_dllp(1'b0, 12'd0);
    checks++; if (bus.tx_block !== 1'b0 || bus.outstanding !== 12'(MAXO - 1)) begin errors++; $display("FAIL full_release got blk=%b out=%0d exp 0 %0d", bus.tx_block, bus.outstanding, MAXO - 1); end
    send_tlp();
    checks++; if (bus.tx_block !== 1'b1 || bus.next_seq !== 12'(MAXO + 1)) begin errors++; $display("FAIL full_refill got blk=%b ns=%0d exp 1 %0d", bus.tx_block, bus.next_seq, MAXO + 1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_tlp(); send_tlp();
    bus.tlp_sent = 1;
    send_dllp(1'b0, 12'd1);
    bus.tlp_sent = 0;
    checks++; if (bus.next_seq !== 12'd3 || bus.ackd_seq !== 12'd1 || bus.outstanding !== 12'd1) begin errors++; $display("FAIL b2b_same_cycle got ns=%0d ack=%0d out=%0d exp 3 1 1", bus.next_seq, bus.ackd_seq, bus.outstanding); end
    checks++; if (bus.purge_valid !== 1'b1 || bus.purge_seq !== 12'd1) begin errors++; $display("FAIL b2b_purge got v=%b s=%0d exp 1 1", bus.purge_valid, bus.purge_seq); end
    send_dllp(1'b0, 12'd1);
    checks++; if (bus.purge_valid !== 1'b0 || bus.dllp_err !== 1'b0 || bus.replay_req !== 1'b0) begin errors++; $display("FAIL b2b_dup_ack got v=%b err=%b req=%b exp 0 0 0", bus.purge_valid, bus.dllp_err, bus.replay_req); end
    send_dllp(1'b1, 12'd1);
    checks++; if (bus.replay_req !== 1'b1 || bus.purge_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup_nak got req=%b v=%b exp 1 0", bus.replay_req, bus.purge_valid); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_ack();
    test_timeout();
    test_nak();
    test_retrain();
    test_wrap();
    test_full();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
